cell_info_arb: RTL
==================

# cell_info_arb

Round-robin scheduler that arbitrates per-channel packet descriptors into the single shared info FIFO read by the first-cell scheduler. A channel is granted only when its cell FIFO already holds every cell the packet needs, so the downstream scheduler never stalls mid-packet on a partly filled cell FIFO. It sits between the per-channel packet parsers and the shared info FIFO, and tracks cell occupancy per channel with its own counters.

## Interface
- CHN_NUM, 6, number of channels (2..8)
- PIMWID, 48, descriptor width
- CNT_WID, 6, per-channel cell counter width (≥ log2(cell FIFO depth)+1)
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- chn_cell_wen  in  CHN_NUM  one-cycle pulse per cell written into channel i's cell FIFO
- chn_info_vld  in  CHN_NUM  channel i presents a descriptor
- chn_info_dat  in  CHN_NUM*PIMWID  descriptor of channel i, slice [i*PIMWID +: PIMWID]
- chn_info_rdy  out  CHN_NUM  one-hot, one-cycle pop pulse to channel i
- info_fifo_wen  out  1  write strobe to the shared info FIFO
- info_fifo_wdata  out  PIMWID  descriptor with cid field replaced
- info_fifo_afull  in  1  info FIFO almost full, asserted with ≥2 free entries left
- cnt_ovf_err  out  CHN_NUM  sticky, per-channel counter overflow or underflow

## Operation
- Descriptor fields:
  - plen = [35:20]
  - cid = [3:0]
  - csz = 8 if plen[15:8]≠0, else ceil(plen/32), i.e. plen[8:5] + |plen[4:0]
  - plen=0 gives csz=0, which is legal
- Channel i is eligible when chn_info_vld[i], cell_cnt[i] ≥ csz_i, and info_fifo_afull=0.
- FSM states and transitions:
  - ARB: if any channel is eligible, register the grant index g and its data, then go to PUSH. Otherwise stay in ARB.
  - PUSH: pulse info_fifo_wen and chn_info_rdy[g]. The write data is chn_info_dat slice g with [3:0] replaced by g. Subtract csz_g from cell_cnt[g], set rr_ptr = (g+1) mod CHN_NUM, and return to ARB.
- Round-robin search starts at rr_ptr and wraps through CHN_NUM-1 → 0. The first eligible channel wins.
- Upstream must hold vld and dat stable until the rdy pulse.
- cell_cnt[i] update:
  - next = cell_cnt + chn_cell_wen[i] − (PUSH && g==i ? csz : 0)
  - A same-cycle increment and decrement are both applied.
- Overflow: an increment at all-ones saturates the counter and sets cnt_ovf_err[i].
- Underflow: a result below zero clamps to 0 and sets cnt_ovf_err[i].
- cnt_ovf_err bits clear only on reset.

## Timing
- Reset values:
  - FSM = ARB, rr_ptr = 0, all cell_cnt = 0, g = 0
  - chn_info_rdy = 0, info_fifo_wen = 0, info_fifo_wdata = 0, cnt_ovf_err = 0
- All outputs are registered.
- Latency: an eligible channel sampled in ARB at cycle N gives wen and rdy at cycle N+1.
- Peak rate is one descriptor per 2 cycles.
- A cell pulse at cycle N is visible to eligibility at N+1.
- afull is sampled only in ARB. A grant already in PUSH completes regardless of afull; the 2-entry margin covers this.
- If vld drops in ARB before a grant, the channel is simply not eligible.
- Asynchronous reset mid-PUSH drops the write. Upstream must re-present the descriptor after reset.

## Structure
- Shared package cell_pkg holds:
  - CID_LSB=0, CID_WID=4, PLEN_LSB=20, PLEN_WID=16, CSZ_WID=4, CELL_SZ=8
  - function csz_of(plen), shared with the first-cell scheduler so the cell-count rule has one source
- Sub-module info_rr_pick (combinational):
  - inputs: eligible vector and rr_ptr
  - outputs: any_grant and grant index
  - built as a double-width masked priority encoder
- The top holds the FSM, counters and output registers.

## Test plan
- Reset, then ch2 gets 3 cell pulses and presents plen=70 (csz=3) → wen 1 cycle after eligibility; wdata[3:0]=2; cell_cnt[2]=0; rdy[2] one pulse.
- ch1 presents plen=300 (csz=8) with 7 cells → no grant; 8th cell pulse → grant 2 cycles later.
- All 6 channels hold plen=32 plus 1 cell each → grants in order 0,1,2,3,4,5, each 2 cycles apart; then rr_ptr=0.
- afull held high with eligible channels → zero wen; release → grant on the next ARB.
- Cell pulse on ch3 in the same cycle as its PUSH with csz=1 and cnt=1 → cnt ends at 1.
- 64 cell pulses into ch0 with CNT_WID=6 → cnt saturates at 63, cnt_ovf_err[0]=1 until reset.

Source files
------------

// File: rtl/cell_pkg.sv
// Shared descriptor field layout and the cell-count rule used by the
// arbiter and the first-cell scheduler.
package cell_pkg;

  localparam int CID_LSB  = 0;
  localparam int CID_WID  = 4;
  localparam int PLEN_LSB = 20;
  localparam int PLEN_WID = 16;
  localparam int CSZ_WID  = 4;
  localparam int CELL_SZ  = 8;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_PUSH = 1'b1
  } arb_state_t;

  // Number of cells a packet of length plen occupies. Anything at or above
  // 256 bytes is capped to a full CELL_SZ-cell allocation; below that, one
  // cell per 32 bytes, rounded up. A zero-length packet needs no cells.
  function automatic logic [CSZ_WID-1:0] csz_of(input logic [PLEN_WID-1:0] plen);
    logic [CSZ_WID-1:0] csz;
    if (|plen[15:8]) begin
      csz = CSZ_WID'(CELL_SZ);
    end else begin
      csz = plen[8:5] + CSZ_WID'(|plen[4:0]);
    end
    return csz;
  endfunction

endpackage

// File: rtl/info_rr_pick.sv
// Round-robin pick: first set bit of the eligible vector at or after
// rr_ptr, wrapping past the top back to channel 0.
module info_rr_pick #(
  parameter int N     = 6,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             any_grant,
  output logic [IDX_W-1:0] grant_idx
);

  localparam int POS_W = $clog2(2 * N);

  // The vector is laid out twice; the low copy is masked below rr_ptr so the
  // first set bit is the next eligible channel in circular order.
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;
  logic [POS_W-1:0] pos;
  logic found;

  genvar gi;
  generate
    for (gi = 0; gi < 2 * N; gi++) begin : g_mask
      if (gi < N) begin : g_low
        assign mask[gi] = (IDX_W'(gi) >= rr_ptr);
      end else begin : g_high
        assign mask[gi] = 1'b1;
      end
    end
  endgenerate

  assign dbl    = {eligible, eligible};
  assign masked = dbl & mask;

  // Lowest set bit of the masked double-width vector.
  always_comb begin
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      if (masked[i] && !found) begin
        pos   = POS_W'(i);
        found = 1'b1;
      end
    end
  end

  // Fold the position in the high copy back onto a channel index.
  always_comb begin
    any_grant = |eligible;
    if (pos >= POS_W'(N)) begin
      grant_idx = IDX_W'(pos - POS_W'(N));
    end else begin
      grant_idx = IDX_W'(pos);
    end
  end

endmodule

// File: rtl/cell_info_arb.sv
// Arbitrates per-channel packet descriptors into the shared info FIFO,
// granting a channel only once its cell FIFO holds the whole packet.
module cell_info_arb
  import cell_pkg::*;
#(
  parameter int CHN_NUM = 6,
  parameter int PIMWID  = 48,
  parameter int CNT_WID = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHN_NUM-1:0]        chn_cell_wen,
  input  logic [CHN_NUM-1:0]        chn_info_vld,
  input  logic [CHN_NUM*PIMWID-1:0] chn_info_dat,
  output logic [CHN_NUM-1:0]        chn_info_rdy,
  output logic                      info_fifo_wen,
  output logic [PIMWID-1:0]         info_fifo_wdata,
  input  logic                      info_fifo_afull,
  output logic [CHN_NUM-1:0]        cnt_ovf_err
);

  localparam int IDX_W = $clog2(CHN_NUM);
  localparam logic [CNT_WID-1:0] CNT_MAX = '1;

  arb_state_t state_reg, state_next;

  logic [IDX_W-1:0]   g_reg, g_next;
  logic [CSZ_WID-1:0] csz_g_reg, csz_g_next;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_next;

  logic [CHN_NUM-1:0] rdy_next;
  logic               wen_next;
  logic [PIMWID-1:0]  wdata_next;

  logic [CNT_WID-1:0] cell_cnt [CHN_NUM];
  logic [CSZ_WID-1:0] csz      [CHN_NUM];
  logic [CHN_NUM-1:0] eligible;

  logic               any_grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [PIMWID-1:0]  grant_dat;

  genvar gi;
  generate
    for (gi = 0; gi < CHN_NUM; gi++) begin : g_elig
      assign csz[gi] = csz_of(chn_info_dat[gi*PIMWID + PLEN_LSB +: PLEN_WID]);
      assign eligible[gi] = chn_info_vld[gi]
                          && (cell_cnt[gi] >= CNT_WID'(csz[gi]))
                          && !info_fifo_afull;
    end
  endgenerate

  info_rr_pick #(
    .N     (CHN_NUM),
    .IDX_W (IDX_W)
  ) u_pick (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .any_grant (any_grant),
    .grant_idx (grant_idx)
  );

  assign grant_dat = chn_info_dat[grant_idx*PIMWID +: PIMWID];

  // State register together with grant context and the registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_ARB;
      g_reg           <= '0;
      csz_g_reg       <= '0;
      rr_ptr          <= '0;
      chn_info_rdy    <= '0;
      info_fifo_wen   <= 1'b0;
      info_fifo_wdata <= '0;
    end else begin
      state_reg       <= state_next;
      g_reg           <= g_next;
      csz_g_reg       <= csz_g_next;
      rr_ptr          <= rr_ptr_next;
      chn_info_rdy    <= rdy_next;
      info_fifo_wen   <= wen_next;
      info_fifo_wdata <= wdata_next;
    end
  end

  // Next-state: grant takes one ARB cycle, the push always takes one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ARB:  if (any_grant) state_next = ST_PUSH;
      ST_PUSH: state_next = ST_ARB;
      default: state_next = ST_ARB;
    endcase
  end

  // Output/context next values: outputs are loaded on the grant edge so they
  // are high exactly during the PUSH cycle.
  always_comb begin
    g_next      = g_reg;
    csz_g_next  = csz_g_reg;
    rr_ptr_next = rr_ptr;
    wen_next    = 1'b0;
    rdy_next    = '0;
    wdata_next  = info_fifo_wdata;
    if (state_reg == ST_ARB && any_grant) begin
      g_next                          = grant_idx;
      csz_g_next                      = csz[grant_idx];
      wen_next                        = 1'b1;
      rdy_next[grant_idx]             = 1'b1;
      wdata_next                      = grant_dat;
      wdata_next[CID_LSB +: CID_WID]  = CID_WID'(grant_idx);
    end
    if (state_reg == ST_PUSH) begin
      rr_ptr_next = (g_reg == IDX_W'(CHN_NUM - 1)) ? '0 : g_reg + 1'b1;
    end
  end

  generate
    for (gi = 0; gi < CHN_NUM; gi++) begin : g_cnt
      logic [CNT_WID-1:0] cnt_reg, cnt_next;
      logic               err_reg, err_next;
      logic               dec_en;
      logic [CNT_WID+1:0] sum;

      // Net occupancy change: one cell in, the granted packet's cells out.
      // Top bit flags underflow, the next one overflow.
      always_comb begin
        dec_en   = (state_reg == ST_PUSH) && (g_reg == IDX_W'(gi));
        sum      = {2'b00, cnt_reg}
                 + (CNT_WID+2)'(chn_cell_wen[gi])
                 - (dec_en ? (CNT_WID+2)'(csz_g_reg) : '0);
        cnt_next = sum[CNT_WID-1:0];
        err_next = err_reg;
        if (sum[CNT_WID+1]) begin
          cnt_next = '0;
          err_next = 1'b1;
        end else if (sum[CNT_WID]) begin
          cnt_next = CNT_MAX;
          err_next = 1'b1;
        end
      end

      // Per-channel counter and sticky error flag.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg <= '0;
          err_reg <= 1'b0;
        end else begin
          cnt_reg <= cnt_next;
          err_reg <= err_next;
        end
      end

      assign cell_cnt[gi]    = cnt_reg;
      assign cnt_ovf_err[gi] = err_reg;
    end
  endgenerate

endmodule
